// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial pattern detector.
// Reset configuration reproduces the classic overlapping 1101 detector.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int         DEFAULT_LEN     = 4;
  localparam logic       DEFAULT_OVERLAP = 1'b1;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter; a clear coincident with an increment counts that event.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with Mealy and registered match outputs.
// Pattern bit 0 corresponds to the most recently accepted bit.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  // The oldest history bit is shifted out before it could ever be compared,
  // so only MAX_LEN-1 bits need to be held.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               load_ok;
  logic               accept;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   cand_fill;

  // Out-of-range lengths make the load a no-op, so the stream keeps flowing.
  assign load_ok   = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept    = in_valid && !load_ok;
  assign cand      = {hist, in_bit};
  assign cand_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = accept && (cand_fill >= len) && (((cand ^ pat) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat  <= MAX_LEN'(DEFAULT_PATTERN);
      len  <= LEN_W'(DEFAULT_LEN);
      ovl  <= DEFAULT_OVERLAP;
      hist <= '0;
      fill <= '0;
    end else if (load_ok) begin
      pat  <= cfg_pattern;
      len  <= cfg_len;
      ovl  <= cfg_overlap;
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= cand[MAX_LEN-2:0];
      fill <= (match && !ovl) ? '0 : cand_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

endmodule
